// File: rtl/vc_credit_arbiter.sv
// vc_credit_arbiter: credit-based round-robin arbiter with wormhole locking.
// Several virtual channels share one output pipeline stage. A VC may send a
// flit only while it holds a downstream credit. Once a multi-flit packet
// wins, the arbiter locks onto that VC until its tail flit has been sent.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   req          per-VC flit-ready request
//   req_tail     per-VC tail marker for the requesting flit
//   stall        downstream stall; no flit may advance while high
//   credit_in    per-VC credit return pulse
//   grant        one-hot (or zero) VC advancing this cycle, combinational
//   pipe_en      downstream pipeline enable (OR of grant), combinational
//   credit_avail registered, bit v set when VC v holds at least one credit
//   locked       registered, arbiter is locked to a packet
//   credit_err   registered sticky credit-overflow flag
module vc_credit_arbiter #(
    parameter int unsigned NUM_VC    = 4,
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_VC-1:0] req,
    input  logic [NUM_VC-1:0] req_tail,
    input  logic              stall,
    input  logic [NUM_VC-1:0] credit_in,
    output logic [NUM_VC-1:0] grant,
    output logic              pipe_en,
    output logic [NUM_VC-1:0] credit_avail,
    output logic              locked,
    output logic              credit_err
);

    localparam int unsigned CREDW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned IDXW  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

    localparam logic [CREDW-1:0] CRED_MAX = CREDW'(BUF_DEPTH);
    localparam logic [IDXW-1:0]  LAST_VC  = IDXW'(NUM_VC - 1);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_next;
    logic [IDXW-1:0]  lock_vc;
    logic [IDXW-1:0]  lock_vc_next;
    logic [IDXW-1:0]  rr_ptr;
    logic [IDXW-1:0]  rr_ptr_next;

    logic [CREDW-1:0] credit      [NUM_VC];
    logic [CREDW-1:0] credit_next [NUM_VC];

    logic [NUM_VC-1:0] eligible;
    logic [NUM_VC-1:0] ovf;

    logic              rr_found;
    logic [IDXW-1:0]   rr_pick;
    logic [IDXW-1:0]   rr_cand;
    logic [IDXW:0]     rr_sum;

    logic              granted;
    logic [IDXW-1:0]   grant_vc;

    // Eligibility; reset masks every request so nothing is granted in reset.
    always_comb begin
        eligible = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            eligible[v] = req[v] & (credit[v] != '0) & ~stall & ~reset;
        end
    end

    // Round-robin search starting at rr_ptr, wrapping past the last VC.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_cand  = '0;
        rr_sum   = '0;
        for (int unsigned i = 0; i < NUM_VC; i++) begin
            rr_sum = {1'b0, rr_ptr} + (IDXW+1)'(i);
            if (rr_sum >= (IDXW+1)'(NUM_VC)) begin
                rr_sum = rr_sum - (IDXW+1)'(NUM_VC);
            end
            rr_cand = rr_sum[IDXW-1:0];
            if (!rr_found && eligible[rr_cand]) begin
                rr_found = 1'b1;
                rr_pick  = rr_cand;
            end
        end
    end

    // Next-state, grant and pointer logic.
    always_comb begin
        state_next   = state;
        lock_vc_next = lock_vc;
        rr_ptr_next  = rr_ptr;
        granted      = 1'b0;
        grant_vc     = '0;
        grant        = '0;

        case (state)
            S_IDLE: begin
                if (rr_found) begin
                    granted  = 1'b1;
                    grant_vc = rr_pick;
                    if (!req_tail[rr_pick]) begin
                        state_next   = S_LOCKED;
                        lock_vc_next = rr_pick;
                    end
                end
            end
            S_LOCKED: begin
                // Only the owning VC may advance; otherwise hold everything.
                if (eligible[lock_vc]) begin
                    granted  = 1'b1;
                    grant_vc = lock_vc;
                    if (req_tail[lock_vc]) begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (granted) begin
            grant[grant_vc] = 1'b1;
            rr_ptr_next     = (grant_vc == LAST_VC) ? '0 : grant_vc + IDXW'(1);
        end
    end

    assign pipe_en = |grant;

    // Credit counters: a grant and a return in the same cycle cancel out;
    // a return onto a full counter saturates and flags an overflow.
    always_comb begin
        ovf = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            credit_next[v] = credit[v];
            case ({grant[v], credit_in[v]})
                2'b10: credit_next[v] = credit[v] - CREDW'(1);
                2'b01: begin
                    if (credit[v] == CRED_MAX) begin
                        ovf[v] = 1'b1;
                    end else begin
                        credit_next[v] = credit[v] + CREDW'(1);
                    end
                end
                default: credit_next[v] = credit[v];
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            lock_vc      <= '0;
            rr_ptr       <= '0;
            credit_avail <= '1;
            locked       <= 1'b0;
            credit_err   <= 1'b0;
            for (int unsigned v = 0; v < NUM_VC; v++) begin
                credit[v] <= CRED_MAX;
            end
        end else begin
            state      <= state_next;
            lock_vc    <= lock_vc_next;
            rr_ptr     <= rr_ptr_next;
            locked     <= (state_next == S_LOCKED);
            credit_err <= credit_err | (|ovf);
            for (int unsigned v = 0; v < NUM_VC; v++) begin
                credit[v]       <= credit_next[v];
                credit_avail[v] <= (credit_next[v] != '0);
            end
        end
    end

endmodule

// File: tb/tb_vc_credit_arbiter.sv
// Directed testbench for vc_credit_arbiter (NUM_VC=4, BUF_DEPTH=4).
// Inputs change 1 time unit after each rising edge; outputs are sampled
// 1 unit later, well before the next edge.
module tb_vc_credit_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] req_tail;
    logic       stall;
    logic [3:0] credit_in;
    logic [3:0] grant;
    logic       pipe_en;
    logic [3:0] credit_avail;
    logic       locked;
    logic       credit_err;

    int n_tests = 0;
    int n_fail  = 0;

    vc_credit_arbiter #(
        .NUM_VC    (4),
        .BUF_DEPTH (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_tail     (req_tail),
        .stall        (stall),
        .credit_in    (credit_in),
        .grant        (grant),
        .pipe_en      (pipe_en),
        .credit_avail (credit_avail),
        .locked       (locked),
        .credit_err   (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply a new input vector and let combinational outputs settle.
    task automatic drive(input logic [3:0] r, input logic [3:0] t,
                         input logic s, input logic [3:0] c);
        req       = r;
        req_tail  = t;
        stall     = s;
        credit_in = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        #1;
        drive(4'b1111, 4'b1111, 1'b0, 4'b0000);
        check("reset_grant", 32'(grant), 32'h0);
        check("reset_pipe_en", 32'(pipe_en), 32'h0);
        tick();
        check("reset_credit_avail", 32'(credit_avail), 32'hf);
        check("reset_locked", 32'(locked), 32'h0);
        check("reset_credit_err", 32'(credit_err), 32'h0);
        reset = 1'b0;

        // Round robin over single-flit packets, credits returned each cycle.
        for (int c = 0; c < 5; c++) begin
            logic [3:0] exp_g;
            exp_g = 4'b0001 << (c % 4);
            drive(4'b1111, 4'b1111, 1'b0, exp_g);
            check($sformatf("rr_grant_%0d", c), 32'(grant), 32'(exp_g));
            check($sformatf("rr_pipe_en_%0d", c), 32'(pipe_en), 32'h1);
            tick();
        end
        check("rr_credit_avail", 32'(credit_avail), 32'hf);
        check("rr_no_err", 32'(credit_err), 32'h0);

        // Wormhole: rr_ptr is at VC1, so VC1 wins and sends a 3-flit packet.
        drive(4'b1111, 4'b0000, 1'b0, 4'b0010);
        check("wh_grant_1", 32'(grant), 32'h2);
        tick();
        check("wh_locked_1", 32'(locked), 32'h1);
        drive(4'b1111, 4'b0000, 1'b0, 4'b0010);
        check("wh_grant_2", 32'(grant), 32'h2);
        tick();
        check("wh_locked_2", 32'(locked), 32'h1);
        drive(4'b1111, 4'b0010, 1'b0, 4'b0010);
        check("wh_grant_3", 32'(grant), 32'h2);
        tick();
        check("wh_unlocked", 32'(locked), 32'h0);
        drive(4'b1111, 4'b1111, 1'b0, 4'b0100);
        check("wh_next_vc2", 32'(grant), 32'h4);
        tick();

        // Lock onto VC1 (rr_ptr now 3, VC1 only requester), then stall.
        drive(4'b0010, 4'b0000, 1'b0, 4'b0010);
        check("st_lock_grant", 32'(grant), 32'h2);
        tick();
        for (int c = 0; c < 2; c++) begin
            drive(4'b1111, 4'b0000, 1'b1, 4'b0000);
            check($sformatf("st_grant_%0d", c), 32'(grant), 32'h0);
            check($sformatf("st_pipe_en_%0d", c), 32'(pipe_en), 32'h0);
            tick();
            check($sformatf("st_locked_%0d", c), 32'(locked), 32'h1);
        end
        // Owner idle while locked: other requesters must still be blocked.
        drive(4'b1101, 4'b1111, 1'b0, 4'b0000);
        check("lk_block_others", 32'(grant), 32'h0);
        tick();
        check("lk_still_locked", 32'(locked), 32'h1);

        // Reset mid-packet.
        reset = 1'b1;
        drive(4'b1111, 4'b0000, 1'b0, 4'b0000);
        check("rst_mid_grant", 32'(grant), 32'h0);
        tick();
        reset = 1'b0;
        check("rst_mid_locked", 32'(locked), 32'h0);
        check("rst_mid_avail", 32'(credit_avail), 32'hf);
        drive(4'b1111, 4'b1111, 1'b0, 4'b0001);
        check("rst_rr_ptr0", 32'(grant), 32'h1);
        tick();

        // Credit exhaustion on VC0: exactly 4 grants from a full counter.
        for (int c = 0; c < 4; c++) begin
            drive(4'b0001, 4'b0001, 1'b0, 4'b0000);
            check($sformatf("ex_grant_%0d", c), 32'(grant), 32'h1);
            tick();
        end
        drive(4'b0001, 4'b0001, 1'b0, 4'b0000);
        check("ex_empty_grant", 32'(grant), 32'h0);
        check("ex_empty_avail", 32'(credit_avail), 32'he);
        tick();
        drive(4'b0001, 4'b0001, 1'b0, 4'b0001);
        check("ex_return_same_cycle", 32'(grant), 32'h0);
        tick();
        check("ex_return_avail", 32'(credit_avail), 32'hf);
        drive(4'b0001, 4'b0001, 1'b0, 4'b0000);
        check("ex_resume", 32'(grant), 32'h1);
        tick();

        // VC2 down to 1 credit, then grant plus return in the same cycle.
        for (int c = 0; c < 3; c++) begin
            drive(4'b0100, 4'b0100, 1'b0, 4'b0000);
            check($sformatf("sim_drain_%0d", c), 32'(grant), 32'h4);
            tick();
        end
        drive(4'b0100, 4'b0100, 1'b0, 4'b0100);
        check("sim_grant", 32'(grant), 32'h4);
        tick();
        check("sim_avail", 32'(credit_avail), 32'he);
        drive(4'b0100, 4'b0100, 1'b0, 4'b0000);
        check("sim_last_credit", 32'(grant), 32'h4);
        tick();
        drive(4'b0100, 4'b0100, 1'b0, 4'b0000);
        check("sim_now_empty", 32'(grant), 32'h0);
        check("sim_empty_avail", 32'(credit_avail), 32'ha);
        tick();

        // Overflow on VC3 while full.
        drive(4'b0000, 4'b0000, 1'b0, 4'b1000);
        tick();
        check("ovf_err", 32'(credit_err), 32'h1);
        for (int c = 0; c < 4; c++) begin
            drive(4'b1000, 4'b1000, 1'b0, 4'b0000);
            check($sformatf("ovf_grant_%0d", c), 32'(grant), 32'h8);
            tick();
        end
        drive(4'b1000, 4'b1000, 1'b0, 4'b0000);
        check("ovf_saturated", 32'(grant), 32'h0);
        tick();
        check("ovf_err_sticky", 32'(credit_err), 32'h1);
        reset = 1'b1;
        drive(4'b0000, 4'b0000, 1'b0, 4'b0000);
        tick();
        reset = 1'b0;
        check("ovf_err_cleared", 32'(credit_err), 32'h0);
        check("ovf_avail_restored", 32'(credit_avail), 32'hf);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vc_credit_arbiter.md
VC_CREDIT_ARBITER -- requirements
Module: vc_credit_arbiter

Interface
REQ-001 Parameter NUM_VC, default 4, number of virtual channels sharing one output pipeline stage (2..16).
REQ-002 Parameter BUF_DEPTH, default 4, downstream buffer slots per VC (1..15); CREDW = $clog2(BUF_DEPTH+1).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  NUM_VC  per-VC request, one flit ready at the head of that VC.
REQ-006 req_tail  input  NUM_VC  per-VC flag, the requesting flit is a packet tail; ignored when the matching req bit is 0.
REQ-007 stall  input  1  downstream pipeline stall; no flit may advance.
REQ-008 credit_in  input  NUM_VC  per-VC credit return pulse, one slot freed downstream.
REQ-009 grant  output  NUM_VC  one-hot or zero, VC whose flit advances this cycle.
REQ-010 pipe_en  output  1  enable for the downstream pipeline register; equals OR of grant.
REQ-011 credit_avail  output  NUM_VC  registered, bit v high when the credit count of VC v is nonzero.
REQ-012 locked  output  1  registered, state machine is in LOCKED.
REQ-013 credit_err  output  1  registered sticky flag, credit overflow seen.

Function
REQ-014 Per-VC credit counter, CREDW bits, range 0..BUF_DEPTH.
REQ-015 VC v eligible = req[v] & (credit[v] != 0) & ~stall.
REQ-016 grant and pipe_en combinational from current state and inputs; zero-cycle latency from req to grant.
REQ-017 State machine: IDLE, LOCKED; lock_vc register holds the owning VC index.
REQ-018 IDLE: round-robin search over eligible VCs from rr_ptr upward, wrapping from NUM_VC-1 to 0; first eligible VC granted.
REQ-019 IDLE grant to VC k with req_tail[k]=0 -> next state LOCKED, lock_vc=k.
REQ-020 IDLE grant to VC k with req_tail[k]=1 (single-flit packet) -> remain IDLE.
REQ-021 Any grant to VC k -> rr_ptr = (k+1) mod NUM_VC on the same edge.
REQ-022 LOCKED: only lock_vc may be granted, when eligible; all other VCs receive no grant.
REQ-023 LOCKED grant with req_tail[lock_vc]=1 -> next state IDLE; otherwise remain LOCKED.
REQ-024 LOCKED with lock_vc ineligible (no req, zero credits, or stall) -> grant=0, remain LOCKED, rr_ptr unchanged.
REQ-025 No grant -> rr_ptr, state and lock_vc unchanged.
REQ-026 Credit update per VC each edge: -1 if granted, +1 if credit_in set; both in the same cycle -> unchanged.
REQ-027 credit_in on a VC at BUF_DEPTH with no grant -> counter saturates at BUF_DEPTH and credit_err set to 1.
REQ-028 credit_err stays 1 until reset.
REQ-029 A credit returned at edge N makes the VC eligible in cycle N+1, not in cycle N.
REQ-030 stall forces grant=0 and pipe_en=0 regardless of state; credit returns still accepted during stall.

Reset
REQ-031 During reset: grant=0, pipe_en=0 (reset overrides eligibility).
REQ-032 After reset: state IDLE, lock_vc=0, rr_ptr=0, every credit counter = BUF_DEPTH, credit_avail all ones, locked=0, credit_err=0.
REQ-033 Reset asserted mid-packet (LOCKED) -> IDLE on the next edge; lock abandoned, credits restored to BUF_DEPTH.

Verification
REQ-034 Round-robin: NUM_VC=4, req=4'b1111, all req_tail=1, no stall, credits returned each cycle -> grants cycle through VC0,1,2,3,0 on consecutive cycles.
REQ-035 Wormhole lock: VC1 sends a 3-flit packet (tail on 3rd) while req=4'b1111 -> grant=4'b0010 for 3 cycles, locked=1 for 2 cycles, then VC2 granted.
REQ-036 Credit exhaustion: BUF_DEPTH=4, VC0 only requesting, no credit_in -> 4 grants, then grant=0 and credit_avail[0]=0; one credit_in -> grant resumes the following cycle.
REQ-037 Simultaneous grant and credit_in on VC2 at count 1 -> count remains 1, credit_avail[2]=1.
REQ-038 Overflow: credit_in[3] with VC3 at BUF_DEPTH -> count stays 4, credit_err=1 until reset.
REQ-039 Stall and reset: stall=1 for 2 cycles while locked to VC1 -> grant=0 and state held; reset while locked -> locked=0, all credits 4, rr_ptr=0.
